conv_maxpool: RTL and testbench

- Downstream neighbour of the 6x6 convolution stage.
- Consumes the convolution result stream: 16-bit samples, row-major, qualified per-sample by in_st.
- Performs 2x2, stride-2 pooling on the fly using a half-width line buffer, with no full-frame storage.
- Emits a 3x3 pooled map, one qualified sample at a time, to the next stage.

---
 rtl/conv_maxpool.sv | 129 ++++++++++++
 tb/tb_conv_maxpool.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_maxpool.sv
// rtl/conv_maxpool.sv - 2x2 stride-2 pooling stage fed by a row-major sample stream
//
// Purpose: pools an IN_DIM x IN_DIM stream into an OUT_DIM x OUT_DIM map using a
//          half-width line buffer and a single hold register.
// Optional feature macro: CONV_POOL_AVG_EN (average pooling instead of max pooling).
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_st      din valid this cycle
//   din        unsigned input sample, row-major
//   dout       pooled sample, held while out_st is low
//   out_st     single-cycle strobe per pooled sample
//   frame_done strobes with the last pooled sample of a frame

module conv_maxpool #(
    parameter int DATA_W = 16,
    parameter int IN_DIM = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_st,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              out_st,
    output logic              frame_done
);

    localparam int OUT_DIM = IN_DIM / 2;
    localparam int CW      = (IN_DIM > 2) ? $clog2(IN_DIM) : 1;
    localparam int LW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam logic [CW-1:0] LAST = CW'(IN_DIM - 1);

`ifdef CONV_POOL_AVG_EN
    localparam int LB_W = DATA_W + 1;
`else
    localparam int LB_W = DATA_W;
`endif

    logic [CW-1:0]     col_q, col_d;
    logic [CW-1:0]     row_q, row_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              out_st_q, out_st_d;
    logic              fd_q, fd_d;

    logic [LB_W-1:0]   lbuf_q [OUT_DIM];
    logic              lbuf_we;
    logic [LW-1:0]     lidx;
    logic [LB_W-1:0]   lbuf_rd;
    logic [LB_W-1:0]   pair;
    logic [DATA_W-1:0] result;

    // Each 2x2 window column owns one line buffer slot.
    assign lidx    = LW'(col_q >> 1);
    assign lbuf_rd = lbuf_q[lidx];

`ifdef CONV_POOL_AVG_EN
    logic [DATA_W+1:0] sum;

    assign pair   = {1'b0, hold_q} + {1'b0, din};
    assign sum    = {1'b0, lbuf_rd} + {2'b00, hold_q} + {2'b00, din};
    assign result = sum[DATA_W+1:2];
`else
    logic [DATA_W-1:0] top_bot;

    assign pair    = (din > hold_q) ? din : hold_q;
    assign top_bot = (lbuf_rd > hold_q) ? lbuf_rd : hold_q;
    assign result  = (din > top_bot) ? din : top_bot;
`endif

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        hold_d   = hold_q;
        dout_d   = dout_q;
        out_st_d = 1'b0;
        fd_d     = 1'b0;
        lbuf_we  = 1'b0;
        if (in_st) begin
            if (col_q == LAST) begin
                col_d = '0;
                row_d = (row_q == LAST) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            if (!col_q[0]) begin
                hold_d = din;
            end else if (!row_q[0]) begin
                lbuf_we = 1'b1;
            end else begin
                // Bottom-right pixel of a window completes the pooled sample.
                out_st_d = 1'b1;
                dout_d   = result;
                fd_d     = (row_q == LAST) && (col_q == LAST);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q    <= '0;
            row_q    <= '0;
            hold_q   <= '0;
            dout_q   <= '0;
            out_st_q <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            hold_q   <= hold_d;
            dout_q   <= dout_d;
            out_st_q <= out_st_d;
            fd_q     <= fd_d;
        end
    end

    // Line buffer needs no reset: every even row rewrites it before the odd row reads it.
    always_ff @(posedge clk) begin
        if (lbuf_we) begin
            lbuf_q[lidx] <= pair;
        end
    end

    assign dout       = dout_q;
    assign out_st     = out_st_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_conv_maxpool.sv
// tb/tb_conv_maxpool.sv - scoreboard testbench for conv_maxpool

module tb_conv_maxpool;

    logic        clk;
    logic        rst_n;
    logic        in_st;
    logic [15:0] din;
    logic [15:0] dout;
    logic        out_st;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    int n_exp    = 0;
    int n_out    = 0;

    int          frame [36];
    logic [16:0] exp_q [$];

    conv_maxpool #(.DATA_W(16), .IN_DIM(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_st      (in_st),
        .din        (din),
        .dout       (dout),
        .out_st     (out_st),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected pooled value for window (wr, wc) of the current frame, with frame_done flag in bit 16.
    function automatic logic [16:0] exp_win(int wr, int wc);
        int a, b, c, d, m;
        logic [31:0] r;
        a = frame[(2*wr)*6 + 2*wc];
        b = frame[(2*wr)*6 + 2*wc + 1];
        c = frame[(2*wr+1)*6 + 2*wc];
        d = frame[(2*wr+1)*6 + 2*wc + 1];
`ifdef CONV_POOL_AVG_EN
        r = 32'(a + b + c + d) >> 2;
`else
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        r = 32'(m);
`endif
        return {(wr == 2) && (wc == 2), r[15:0]};
    endfunction

    // Scoreboard monitor: every out_st pops one expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_st) begin
                checks++;
                n_out++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_out dout=%h frame_done=%b required=no output", dout, frame_done);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    if (dout !== e[15:0] || frame_done !== e[16]) begin
                        failures++;
                        $display("FAIL pooled_out dout=%h frame_done=%b required dout=%h frame_done=%b",
                                 dout, frame_done, e[15:0], e[16]);
                    end
                end
            end else if (frame_done !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL stray_frame_done frame_done=%b required=0", frame_done);
            end
        end
    end

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_st = 1'b0;
        end
    endtask

    task automatic drive_px(int idx);
        int r, c;
        r = idx / 6;
        c = idx % 6;
        @(negedge clk);
        in_st = 1'b1;
        din   = 16'(frame[idx]);
        if (r[0] && c[0]) begin
            exp_q.push_back(exp_win(r / 2, c / 2));
            n_exp++;
        end
    endtask

    task automatic send_range(int lo, int hi, int gap_every);
        for (int i = lo; i <= hi; i++) begin
            drive_px(i);
            if (gap_every != 0 && ((i + 1) % gap_every) == 0) idle(3);
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 36; i++) frame[i] = i;
    endtask

    task automatic fill_const(int v);
        for (int i = 0; i < 36; i++) frame[i] = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_st = 1'b0;
        din   = '0;
        #12;
        checks++;
        if (dout !== 16'h0 || out_st !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state dout=%h out_st=%b frame_done=%b required 0/0/0", dout, out_st, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ramp();
        fill_ramp();
        send_range(0, 6, 0);
        @(posedge clk);
        #1;
        checks++;
        if (out_st !== 1'b0) begin
            failures++;
            $display("FAIL early_out out_st=%b required=0", out_st);
        end
        drive_px(7);
        @(posedge clk);
        #1;
        checks++;
        if (out_st !== 1'b1 || dout !== 16'd7) begin
            failures++;
            $display("FAIL first_latency out_st=%b dout=%h required out_st=1 dout=0007", out_st, dout);
        end
        send_range(8, 35, 0);
        idle(2);
    endtask

    task automatic test_gaps();
        fill_ramp();
        send_range(0, 35, 5);
        idle(2);
    endtask

    task automatic test_back_to_back();
        fill_const(16'hFFFF);
        send_range(0, 35, 0);
        fill_const(16'h0001);
        send_range(0, 35, 0);
        idle(2);
    endtask

    task automatic test_midframe_reset();
        fill_ramp();
        send_range(0, 19, 0);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== 16'h0 || out_st !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset dout=%h out_st=%b frame_done=%b required 0/0/0", dout, out_st, frame_done);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pre_reset_drain pending=%0d required=0", exp_q.size());
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_range(0, 35, 0);
        idle(2);
    endtask

    task automatic test_single_peak();
        fill_const(0);
        frame[2*6 + 3] = 16'h8000;
        send_range(0, 35, 0);
        idle(2);
    endtask

    task automatic test_drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
        end
        checks++;
        if (n_out != n_exp) begin
            failures++;
            $display("FAIL output_count got=%0d required=%0d", n_out, n_exp);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_gaps();
        test_back_to_back();
        test_midframe_reset();
        test_single_peak();
        test_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required=finish before timeout", $time);
        $fatal(1, "timeout");
    end

endmodule
